// File: rtl/cma_error_gen.sv
// cma_error_gen: CMA error e = y*(y^2 - R2) with aligned y and a gated update strobe.
// Latency 3 cycles, one sample per cycle; no backpressure (i_valid is never stalled).
module cma_error_gen #(
  parameter int NB_I    = 18,
  parameter int NBF_I   = 15,
  parameter int NB      = 8,
  parameter int NBF     = 7,
  parameter int N_WAIT  = 64,
  parameter int UPD_DIV = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [NB_I-1:0] i_fir_out,
  input  logic [NB_I-1:0] i_r2,
  input  logic            i_adapt_en,
  output logic            o_valid,
  output logic [NB-1:0]   o_error,
  output logic [NB_I-1:0] o_fir_out,
  output logic            o_upd_en,
  output logic            o_sat
);

  localparam int SW = 2 * NB_I;
  localparam int DW = 2 * NB_I + 1;
  localparam int PW = 3 * NB_I + 1;
  localparam int SH = 3 * NBF_I - NBF;
  localparam int WW = (N_WAIT > 0) ? $clog2(N_WAIT + 1) : 1;
  localparam int CW = (UPD_DIV > 1) ? $clog2(UPD_DIV) : 1;
  localparam logic signed [PW-1:0] E_MAX = PW'(2 ** (NB - 1) - 1);
  localparam logic signed [PW-1:0] E_MIN = ~E_MAX;

  logic                   vld1_q, vld1_d;
  logic signed [SW-1:0]   sq_q, sq_d;
  logic signed [NB_I-1:0] y1_q, y1_d;
  logic                   vld2_q, vld2_d;
  logic signed [DW-1:0]   diff_q, diff_d;
  logic signed [NB_I-1:0] y2_q, y2_d;
  logic                   vld3_q, vld3_d;
  logic [NB-1:0]          err_q, err_d;
  logic [NB_I-1:0]        fir_q, fir_d;
  logic                   sat_q, sat_d;
  logic                   upd_q, upd_d;
  logic [WW-1:0]          wcnt_q, wcnt_d;
  logic [CW-1:0]          dcnt_q, dcnt_d;

  logic signed [NB_I-1:0] y_in;
  logic signed [DW-1:0]   sq_ext;
  logic signed [DW-1:0]   r2_ext;
  logic signed [PW-1:0]   prod;
  logic signed [PW-1:0]   trunc;
  logic [NB-1:0]          err_clip;
  logic                   clip;
  logic                   warm_done;

  // S1: square the input sample
  always_comb begin
    y_in   = $signed(i_fir_out);
    vld1_d = i_valid;
    sq_d   = sq_q;
    y1_d   = y1_q;
    if (i_valid) begin
      sq_d = SW'(y_in) * SW'(y_in);
      y1_d = y_in;
    end
  end

  // S2: subtract R2 aligned to the 2*NBF_I fractional grid of sq
  always_comb begin
    sq_ext = DW'(sq_q);
    r2_ext = {{(DW - NB_I - NBF_I){i_r2[NB_I-1]}}, i_r2, {NBF_I{1'b0}}};
    vld2_d = vld1_q;
    diff_d = diff_q;
    y2_d   = y2_q;
    if (vld1_q) begin
      diff_d = sq_ext - r2_ext;
      y2_d   = y1_q;
    end
  end

  // S3: full-precision product, floor to the output grid, then clip
  always_comb begin
    prod  = PW'(y2_q) * PW'(diff_q);
    trunc = prod >>> SH;
    clip  = (trunc > E_MAX) || (trunc < E_MIN);
    if (trunc > E_MAX) begin
      err_clip = {1'b0, {(NB - 1){1'b1}}};
    end else if (trunc < E_MIN) begin
      err_clip = {1'b1, {(NB - 1){1'b0}}};
    end else begin
      err_clip = trunc[NB-1:0];
    end

    vld3_d = vld2_q;
    err_d  = err_q;
    fir_d  = fir_q;
    sat_d  = 1'b0;
    if (vld2_q) begin
      err_d = err_clip;
      fir_d = y2_q;
      sat_d = clip;
    end
  end

  // Counters step with each sample entering the output register, so
  // back-to-back samples each see the count of all earlier outputs.
  always_comb begin
    warm_done = (wcnt_q == WW'(N_WAIT));
    upd_d     = vld2_q & i_adapt_en & warm_done & (dcnt_q == '0);
    wcnt_d    = wcnt_q;
    dcnt_d    = dcnt_q;
    if (vld2_q) begin
      if (!warm_done) begin
        wcnt_d = wcnt_q + WW'(1);
      end else if (dcnt_q == CW'(UPD_DIV - 1)) begin
        dcnt_d = '0;
      end else begin
        dcnt_d = dcnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld1_q <= 1'b0;
      sq_q   <= '0;
      y1_q   <= '0;
      vld2_q <= 1'b0;
      diff_q <= '0;
      y2_q   <= '0;
      vld3_q <= 1'b0;
      err_q  <= '0;
      fir_q  <= '0;
      sat_q  <= 1'b0;
      upd_q  <= 1'b0;
      wcnt_q <= '0;
      dcnt_q <= '0;
    end else begin
      vld1_q <= vld1_d;
      sq_q   <= sq_d;
      y1_q   <= y1_d;
      vld2_q <= vld2_d;
      diff_q <= diff_d;
      y2_q   <= y2_d;
      vld3_q <= vld3_d;
      err_q  <= err_d;
      fir_q  <= fir_d;
      sat_q  <= sat_d;
      upd_q  <= upd_d;
      wcnt_q <= wcnt_d;
      dcnt_q <= dcnt_d;
    end
  end

  assign o_valid   = vld3_q;
  assign o_error   = err_q;
  assign o_fir_out = fir_q;
  assign o_sat     = sat_q;
  assign o_upd_en  = upd_q;

endmodule

// File: tb/tb_cma_error_gen.sv
// Bench for cma_error_gen: directed test-plan sequences plus random traffic,
// every cycle compared against an arithmetic model of the error/strobe rules.
module tb_cma_error_gen;

  localparam int NB_I    = 18;
  localparam int NBF_I   = 15;
  localparam int NB      = 8;
  localparam int NBF     = 7;
  localparam int N_WAIT  = 4;
  localparam int UPD_DIV = 3;
  localparam int R_ONE   = 32768;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            i_valid;
  logic [NB_I-1:0] i_fir_out;
  logic [NB_I-1:0] i_r2;
  logic            i_adapt_en;
  logic            o_valid;
  logic [NB-1:0]   o_error;
  logic [NB_I-1:0] o_fir_out;
  logic            o_upd_en;
  logic            o_sat;

  cma_error_gen #(
    .NB_I(NB_I), .NBF_I(NBF_I), .NB(NB), .NBF(NBF), .N_WAIT(N_WAIT), .UPD_DIV(UPD_DIV)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_fir_out(i_fir_out),
    .i_r2(i_r2), .i_adapt_en(i_adapt_en), .o_valid(o_valid), .o_error(o_error),
    .o_fir_out(o_fir_out), .o_upd_en(o_upd_en), .o_sat(o_sat)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // e = floor(y*(y^2 - R2) / 2^(3*NBF_I-NBF)), clipped to NB bits
  function automatic longint raw_err(input int y, input int r2);
    longint yy, d, p;
    yy = y;
    d  = yy * yy - longint'(r2) * (longint'(1) <<< NBF_I);
    p  = yy * d;
    return p >>> (3 * NBF_I - NBF);
  endfunction

  function automatic longint clip_err(input longint t);
    longint hi, lo;
    hi = (longint'(1) <<< (NB - 1)) - 1;
    lo = -(longint'(1) <<< (NB - 1));
    if (t > hi) return hi;
    if (t < lo) return lo;
    return t;
  endfunction

  // Model: two-entry history of samples accepted on recent edges.
  bit     h0_vld, h1_vld;
  int     h0_y, h1_y, h0_r2;
  bit     e_vld, e_sat, e_upd;
  longint e_err, e_fir;
  int     n_out;

  task automatic step(input bit rst, input bit vld, input int y, input int r2, input bit adapt);
    longint t;
    i_rst      = rst;
    i_valid    = vld;
    i_fir_out  = y[NB_I-1:0];
    i_r2       = r2[NB_I-1:0];
    i_adapt_en = adapt;
    @(posedge i_clk);
    if (rst) begin
      h0_vld = 0; h1_vld = 0;
      e_vld = 0; e_sat = 0; e_upd = 0; e_err = 0; e_fir = 0;
      n_out = 0;
    end else begin
      if (h1_vld) begin
        t     = raw_err(h1_y, h0_r2);
        e_vld = 1;
        e_err = clip_err(t);
        e_sat = (t != e_err);
        e_fir = h1_y;
        e_upd = adapt && (n_out >= N_WAIT) && (((n_out - N_WAIT) % UPD_DIV) == 0);
        n_out++;
      end else begin
        e_vld = 0; e_sat = 0; e_upd = 0;
      end
      h1_vld = h0_vld; h1_y = h0_y;
      h0_vld = vld;    h0_y = y;    h0_r2 = r2;
    end
    @(negedge i_clk);
    check("o_valid",   o_valid,             e_vld);
    check("o_error",   $signed(o_error),    e_err);
    check("o_fir_out", $signed(o_fir_out),  e_fir);
    check("o_sat",     o_sat,               e_sat);
    check("o_upd_en",  o_upd_en,            e_upd);
  endtask

  task automatic idle(input int n, input bit adapt);
    for (int k = 0; k < n; k++) step(0, 0, 0, R_ONE, adapt);
  endtask

  int specials[10] = '{16384, -16384, 32768, -32768, 49152, -49152, 0, 131071, -131072, 1};

  initial begin
    int y, r2;
    bit vld, adapt, rst;

    // Reset state
    step(1, 0, 0, R_ONE, 1);
    step(1, 0, 0, R_ONE, 1);

    // Warm-up: samples 1..4 give no strobe
    for (int k = 0; k < 4; k++) step(0, 1, 16384, R_ONE, 1);
    idle(4, 1);

    // Latency/value: 0.5 -> -48, 1.0 -> 0; saturation at +/-1.5
    step(0, 1, 16384, R_ONE, 1);  idle(4, 1);
    step(0, 1, 32768, R_ONE, 1);  idle(4, 1);
    step(0, 1, 49152, R_ONE, 1);  idle(4, 1);
    step(0, 1, -49152, R_ONE, 1); idle(4, 1);

    // Back-to-back alternating stream
    for (int k = 0; k < 10; k++) step(0, 1, (k % 2 == 0) ? 16384 : -16384, R_ONE, 1);
    idle(4, 1);

    // Warm-up/decimation with gaps and adapt disabled on samples 5..7
    step(1, 0, 0, R_ONE, 1);
    for (int k = 1; k <= 12; k++) begin
      step(0, 1, 16384, R_ONE, !(k >= 5 && k <= 7));
      if (k % 4 == 0) idle(2, !(k >= 4 && k <= 6));
    end
    idle(4, 1);

    // Reset with three samples in flight, then warm-up restarts
    step(0, 1, 16384, R_ONE, 1);
    step(0, 1, -16384, R_ONE, 1);
    step(1, 1, 49152, R_ONE, 1);
    idle(4, 1);
    for (int k = 0; k < 8; k++) step(0, 1, -16384, R_ONE, 1);
    idle(4, 1);

    // Random traffic
    r2 = R_ONE;
    for (int k = 0; k < 3000; k++) begin
      case ($urandom_range(0, 3))
        0: y = int'($urandom_range(0, 262143)) - 131072;
        1: y = int'($urandom_range(0, 80000)) - 40000;
        2: y = (($urandom_range(0, 1) == 1) ? 1 : -1) * (R_ONE + int'($urandom_range(0, 4000)) - 2000);
        default: y = specials[$urandom_range(0, 9)];
      endcase
      if ($urandom_range(0, 99) == 0) r2 = int'($urandom_range(0, 65536));
      vld   = ($urandom_range(0, 9) < 6);
      adapt = ($urandom_range(0, 9) < 8);
      rst   = ($urandom_range(0, 299) == 0);
      step(rst, vld, y, r2, adapt);
    end
    idle(4, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
